stopwatch_display: RTL and testbench



---
 rtl/stopwatch_display_if.sv | 20 ++
 rtl/stopwatch_display.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_display.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_display_if.sv
// Bundle between the stopwatch core (master) and the MM:SS display driver (slave).
interface stopwatch_display_if;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       ovf;

  modport master (
    output minutes, seconds, status,
    input  seg, an, dp, ovf
  );

  modport slave (
    input  minutes, seconds, status,
    output seg, an, dp, ovf
  );
endinterface

// File: rtl/stopwatch_display.sv
// 4-digit multiplexed common-anode MM:SS display driver with a free-running double-dabble
// converter. Optional pause blinking is enabled by defining STOPWATCH_DISP_BLINK_EN.
module stopwatch_display #(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned BLINK_DIV   = 64
) (
  input logic                 clk,
  input logic                 rst,
  stopwatch_display_if.slave  disp
);

  localparam int unsigned ScanW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {StCapture, StShift, StCommit} state_e;

  state_e          state_q;
  logic [2:0]      shift_cnt_q;
  logic [14:0]     eng_m_q;
  logic [14:0]     eng_s_q;
  logic            ovf_cand_q;
  logic            ovf_q;
  logic [3:0][3:0] dig_q;

  logic [ScanW-1:0] scan_q;
  logic [1:0]       idx_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic clamp;
  logic blank;

  assign clamp = disp.minutes > 8'd99;

  // One double-dabble iteration on {tens, ones, binary[6:0]}: adjust nibbles, then shift.
  function automatic logic [14:0] dd_step(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Digits and ovf only change in StCommit, so a partially converted value is never shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StCapture;
      shift_cnt_q <= '0;
      eng_m_q     <= '0;
      eng_s_q     <= '0;
      ovf_cand_q  <= 1'b0;
      ovf_q       <= 1'b0;
      dig_q       <= '0;
    end else begin
      case (state_q)
        StCapture: begin
          eng_m_q     <= {8'd0, clamp ? 7'd99 : disp.minutes[6:0]};
          eng_s_q     <= {8'd0, 1'b0, disp.seconds};
          ovf_cand_q  <= clamp;
          shift_cnt_q <= '0;
          state_q     <= StShift;
        end
        StShift: begin
          eng_m_q <= dd_step(eng_m_q);
          eng_s_q <= dd_step(eng_s_q);
          if (shift_cnt_q == 3'd6) begin
            state_q <= StCommit;
          end else begin
            shift_cnt_q <= shift_cnt_q + 3'd1;
          end
        end
        StCommit: begin
          dig_q[0] <= eng_s_q[10:7];
          dig_q[1] <= eng_s_q[14:11];
          dig_q[2] <= eng_m_q[10:7];
          dig_q[3] <= eng_m_q[14:11];
          ovf_q    <= ovf_cand_q;
          state_q  <= StCapture;
        end
        default: state_q <= StCapture;
      endcase
    end
  end

  // Outputs are registered from the current index, so an[0] is driven from the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      if (scan_q == ScanW'(REFRESH_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      seg_q <= seg_enc(dig_q[idx_q]);
      if (blank) begin
        an_q <= 4'b1111;
        dp_q <= 1'b1;
      end else begin
        an_q <= ~(4'b0001 << idx_q);
        dp_q <= (idx_q != 2'd2);
      end
    end
  end

`ifdef STOPWATCH_DISP_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (disp.status == 2'b10) begin
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blank_q     <= ~blank_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end
  end

  assign blank = blank_q;
`else
  logic unused_cfg;

  assign blank      = 1'b0;
  assign unused_cfg = ^{disp.status, BLINK_DIV[0]};
`endif

  assign disp.seg = seg_q;
  assign disp.an  = an_q;
  assign disp.dp  = dp_q;
  assign disp.ovf = ovf_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed, table-driven bench for stopwatch_display: reset, conversion, clamp, scan, async reset
// and pause blinking.
module tb_stopwatch_display;

  localparam int unsigned RefreshDiv = 4;
  localparam int unsigned BlinkDiv   = 64;

  typedef struct {
    logic [7:0]  minutes;
    logic [5:0]  seconds;
    logic [27:0] segs;   // {an3, an2, an1, an0} expected cathodes
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  stopwatch_display_if bus ();

  stopwatch_display #(
    .REFRESH_DIV (RefreshDiv),
    .BLINK_DIV   (BlinkDiv)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int an_to_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Watch two full scan rotations and compare what each digit position shows.
  task automatic check_frame(input string name, input logic [27:0] exp_segs, input logic exp_ovf);
    logic [6:0] got [4];
    int         seen;
    int         bad;
    int         k;
    seen = 0;
    bad  = 0;
    for (int j = 0; j < 4; j++) got[j] = 7'h7F;
    for (int c = 0; c < int'(8 * RefreshDiv); c++) begin
      @(negedge clk);
      k = an_to_idx(bus.an);
      if (k < 0) begin
        bad++;
      end else begin
        got[k] = bus.seg;
        seen   = seen | (1 << k);
        if (bus.dp !== ((k == 2) ? 1'b0 : 1'b1)) bad++;
      end
    end
    if (seen != 15) bad++;
    check({name, " scan"}, 32'(bad), 32'd0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s digit%0d", name, j), 32'(got[j]), 32'(exp_segs[7*j +: 7]));
    end
    check({name, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    vec_t       vecs [10];
    logic [6:0] old_seg [4];
    logic [6:0] new_seg [4];
    logic [3:0] pat [4];
    logic [3:0] prev_an;
    int         bad;
    int         k;
    int         found;

    vecs[0] = '{8'd12,  6'd34, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vecs[1] = '{8'd0,   6'd59, {7'h40, 7'h40, 7'h12, 7'h10}, 1'b0};
    vecs[2] = '{8'd1,   6'd0,  {7'h40, 7'h79, 7'h40, 7'h40}, 1'b0};
    vecs[3] = '{8'd150, 6'd7,  {7'h10, 7'h10, 7'h40, 7'h78}, 1'b1};
    vecs[4] = '{8'd99,  6'd7,  {7'h10, 7'h10, 7'h40, 7'h78}, 1'b0};
    vecs[5] = '{8'd255, 6'd63, {7'h10, 7'h10, 7'h02, 7'h30}, 1'b1};
    vecs[6] = '{8'd100, 6'd60, {7'h10, 7'h10, 7'h02, 7'h40}, 1'b1};
    vecs[7] = '{8'd45,  6'd18, {7'h19, 7'h12, 7'h79, 7'h00}, 1'b0};
    vecs[8] = '{8'd128, 6'd0,  {7'h10, 7'h10, 7'h40, 7'h40}, 1'b1};
    vecs[9] = '{8'd9,   6'd9,  {7'h40, 7'h10, 7'h40, 7'h10}, 1'b0};

    pat[0] = 4'b1110;
    pat[1] = 4'b1101;
    pat[2] = 4'b1011;
    pat[3] = 4'b0111;

    // Reset held for three cycles.
    bus.minutes = vecs[0].minutes;
    bus.seconds = vecs[0].seconds;
    bus.status  = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("reset outputs", 32'({bus.an, bus.seg, bus.dp, bus.ovf}),
            32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    end
    rst = 1'b0;

    @(negedge clk);
    check("first an", 32'(bus.an), 32'(4'b1110));
    check("first seg", 32'(bus.seg), 32'(7'h40));
    bad = 0;
    for (int e = 2; e <= 9; e++) begin
      @(negedge clk);
      if (bus.seg !== 7'h40) bad++;
    end
    check("zeros before commit", 32'(bad), 32'd0);
    check_frame("vec0", vecs[0].segs, vecs[0].ovf);

    for (int i = 1; i < 10; i++) begin
      bus.minutes = vecs[i].minutes;
      bus.seconds = vecs[i].seconds;
      repeat (18) @(posedge clk);
      check_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].ovf);
    end

    // 00:59 -> 01:00 at a random phase; only old or new digits may ever appear.
    bus.minutes = 8'd0;
    bus.seconds = 6'd59;
    repeat (20) @(negedge clk);
    repeat ($urandom_range(0, 8)) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      old_seg[j] = vecs[1].segs[7*j +: 7];
      new_seg[j] = vecs[2].segs[7*j +: 7];
    end
    bus.minutes = 8'd1;
    bus.seconds = 6'd0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      k = an_to_idx(bus.an);
      if (k < 0) bad++;
      else if (bus.seg !== old_seg[k] && bus.seg !== new_seg[k]) bad++;
    end
    check("no intermediate digits", 32'(bad), 32'd0);
    check_frame("latency 01:00", vecs[2].segs, 1'b0);

    // Scan rotation at 00:00.
    bus.minutes = 8'd0;
    bus.seconds = 6'd0;
    repeat (20) @(negedge clk);
    found = 0;
    for (int c = 0; c < 64 && found == 0; c++) begin
      prev_an = bus.an;
      @(negedge clk);
      if (bus.an == 4'b1110 && prev_an == 4'b0111) found = 1;
    end
    check("rotation sync", 32'(found), 32'd1);
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      if (bus.an !== pat[(i / RefreshDiv) % 4]) bad++;
      if (bus.dp !== ((pat[(i / RefreshDiv) % 4] == 4'b1011) ? 1'b0 : 1'b1)) bad++;
      @(negedge clk);
    end
    check("rotation sequence", 32'(bad), 32'd0);

    // Async reset three cycles into SHIFT of the third pass after release.
    rst = 1'b1;
    bus.minutes = 8'd150;
    bus.seconds = 6'd7;
    @(negedge clk);
    rst = 1'b0;
    repeat (22) @(posedge clk);
    #2;
    check("pre-reset ovf", 32'(bus.ovf), 32'd1);
    rst = 1'b1;
    #1;
    check("async reset outputs", 32'({bus.an, bus.seg, bus.dp, bus.ovf}),
          32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    bus.minutes = vecs[7].minutes;
    bus.seconds = vecs[7].seconds;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    check_frame("after async reset", vecs[7].segs, vecs[7].ovf);

`ifdef STOPWATCH_DISP_BLINK_EN
    bus.status = 2'b10;
    bad = 0;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk);
      if ((bus.an == 4'hF) != ((((e - 1) / BlinkDiv) % 2) == 1)) bad++;
    end
    check("blink pattern", 32'(bad), 32'd0);
    bus.status = 2'b01;
    @(negedge clk);
    check("blank one more cycle", 32'(bus.an), 32'hF);
    @(negedge clk);
    check("unblanked", 32'(bus.an == 4'hF), 32'd0);
`else
    bus.status = 2'b10;
    bad = 0;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk);
      if (bus.an == 4'hF) bad++;
    end
    check("no blanking", 32'(bad), 32'd0);
`endif
    bus.status = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
